// File: rtl/isp_ctrl_regs_pkg.sv
// Shared constants for the ISP control register block: UART command bytes,
// gamma select codes and the command FSM state encoding.
package isp_ctrl_pkg;

  localparam logic [7:0] CMD_MODE   = 8'h4D;  // 'M'
  localparam logic [7:0] CMD_GAMMA  = 8'h47;  // 'G'
  localparam logic [7:0] CMD_QUERY  = 8'h3F;  // '?'
  localparam logic [7:0] ASCII_ZERO = 8'h30;  // '0'

  localparam logic [1:0] GAMMA_1P8 = 2'd1;
  localparam logic [1:0] GAMMA_2P2 = 2'd2;
  localparam logic [1:0] GAMMA_2P4 = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARG_M,
    ST_ARG_G,
    ST_TX0,
    ST_TX1
  } cmd_state_e;

  function automatic logic [7:0] to_ascii(input logic [3:0] v);
    return ASCII_ZERO + {4'h0, v};
  endfunction

endpackage

// File: rtl/isp_ctrl_regs_if.sv
// UART byte link between the receiver/transmitter pair and the control block.
interface isp_ctrl_regs_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (output rx_valid, output rx_data, output tx_ready,
                  input  tx_valid, input  tx_data);
  modport slave  (input  rx_valid, input  rx_data, input  tx_ready,
                  output tx_valid, output tx_data);
endinterface

// File: rtl/isp_ctrl_regs_btn_debounce.sv
// Push-button conditioning: 2-FF synchronizer, stability debouncer and a
// registered one-cycle press pulse on each 0->1 of the debounced level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk50m,
  input  logic reset_n,
  input  logic button,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          btn_p0;
  logic          btn_p1;
  logic          stable;
  logic [CW-1:0] cnt;

  // Synchronizer stages p0/p1, then the debounce counter on btn_p1
  always_ff @(posedge clk50m or negedge reset_n) begin
    if (!reset_n) begin
      btn_p0 <= 1'b0;
      btn_p1 <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      btn_p0 <= button;
      btn_p1 <= btn_p0;
      press  <= 1'b0;
      if (btn_p1 == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt    <= '0;
        stable <= btn_p1;
        press  <= btn_p1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/isp_ctrl_regs.sv
// ISP display-mode / gamma control registers: UART command parser, button
// mode stepping, and vsync-aligned application of the pending settings.
module isp_ctrl_regs
  import isp_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int MODE_NUM        = 6,
  parameter int CMD_TIMEOUT     = 5_000_000
) (
  input  logic              clk50m,
  input  logic              reset_n,
  isp_ctrl_regs_if.slave    uart,
  input  logic              button,
  input  logic              frame_vsync,
  output logic [3:0]        isp_mode,
  output logic [1:0]        gamma_type,
  output logic              cmd_error
);

  localparam int         TW            = $clog2(CMD_TIMEOUT + 1);
  localparam logic [7:0] MODE_MAX_CHAR = ASCII_ZERO + 8'(MODE_NUM);

  cmd_state_e    state, state_nx;
  logic [3:0]    pend_mode;
  logic [1:0]    pend_gamma;
  logic [3:0]    snap_mode;
  logic [1:0]    snap_gamma;
  logic [TW-1:0] to_cnt;
  logic          vs_p0, vs_p1, vs_p2;
  logic          apply_strobe;
  logic          press;
  logic          err_nx;
  logic          mode_wr;
  logic          gamma_wr;
  logic          snap_ld;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk50m  (clk50m),
    .reset_n (reset_n),
    .button  (button),
    .press   (press)
  );

  // vsync synchronizer p0/p1; p2 holds the previous sample for edge detect
  always_ff @(posedge clk50m or negedge reset_n) begin
    if (!reset_n) begin
      vs_p0 <= 1'b0;
      vs_p1 <= 1'b0;
      vs_p2 <= 1'b0;
    end else begin
      vs_p0 <= frame_vsync;
      vs_p1 <= vs_p0;
      vs_p2 <= vs_p1;
    end
  end

  assign apply_strobe = vs_p1 & ~vs_p2;

  always_comb begin
    state_nx = state;
    err_nx   = 1'b0;
    mode_wr  = 1'b0;
    gamma_wr = 1'b0;
    snap_ld  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (uart.rx_valid) begin
          case (uart.rx_data)
            CMD_MODE:  state_nx = ST_ARG_M;
            CMD_GAMMA: state_nx = ST_ARG_G;
            CMD_QUERY: begin
              state_nx = ST_TX0;
              snap_ld  = 1'b1;
            end
            default:   err_nx = 1'b1;
          endcase
        end
      end
      ST_ARG_M: begin
        if (uart.rx_valid) begin
          state_nx = ST_IDLE;
          if (uart.rx_data >= ASCII_ZERO && uart.rx_data <= MODE_MAX_CHAR) mode_wr = 1'b1;
          else err_nx = 1'b1;
        end else if (to_cnt == TW'(CMD_TIMEOUT - 1)) begin
          state_nx = ST_IDLE;
          err_nx   = 1'b1;
        end
      end
      ST_ARG_G: begin
        if (uart.rx_valid) begin
          state_nx = ST_IDLE;
          if (uart.rx_data >= (ASCII_ZERO + 8'd1) && uart.rx_data <= (ASCII_ZERO + 8'd3)) gamma_wr = 1'b1;
          else err_nx = 1'b1;
        end else if (to_cnt == TW'(CMD_TIMEOUT - 1)) begin
          state_nx = ST_IDLE;
          err_nx   = 1'b1;
        end
      end
      ST_TX0: begin
        err_nx = uart.rx_valid;
        if (uart.tx_ready) state_nx = ST_TX1;
      end
      ST_TX1: begin
        err_nx = uart.rx_valid;
        if (uart.tx_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk50m or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      to_cnt     <= '0;
      cmd_error  <= 1'b0;
      snap_mode  <= 4'd0;
      snap_gamma <= 2'd0;
    end else begin
      state     <= state_nx;
      cmd_error <= err_nx;
      // Timeout only runs while parked in an argument state
      if ((state == ST_ARG_M || state == ST_ARG_G) && state_nx == state) to_cnt <= to_cnt + TW'(1);
      else to_cnt <= '0;
      // Response bytes are frozen at the query so a press cannot alter them mid-handshake
      if (snap_ld) begin
        snap_mode  <= pend_mode;
        snap_gamma <= pend_gamma;
      end
    end
  end

  // Argument digits are range-checked above, so the low bits equal byte - '0'
  always_ff @(posedge clk50m or negedge reset_n) begin
    if (!reset_n) begin
      pend_mode  <= 4'd0;
      pend_gamma <= GAMMA_2P2;
      isp_mode   <= 4'd0;
      gamma_type <= GAMMA_2P2;
    end else begin
      if (mode_wr) pend_mode <= uart.rx_data[3:0];
      else if (press) pend_mode <= (pend_mode == 4'(MODE_NUM)) ? 4'd0 : pend_mode + 4'd1;
      if (gamma_wr) pend_gamma <= uart.rx_data[1:0];
      if (apply_strobe) begin
        isp_mode   <= pend_mode;
        gamma_type <= pend_gamma;
      end
    end
  end

  assign uart.tx_valid = (state == ST_TX0) || (state == ST_TX1);
  assign uart.tx_data  = (state == ST_TX0) ? to_ascii(snap_mode) :
                         (state == ST_TX1) ? to_ascii({2'b00, snap_gamma}) : 8'h00;

endmodule

// File: doc/isp_ctrl_regs.md
ISP_CTRL_REGS -- requirements
Module: isp_ctrl_regs

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, meaning the number of cycles the button must be stable (20 ms at 50 MHz).
REQ-002 SHALL have parameter MODE_NUM, default 6, meaning the highest valid isp_mode value.
REQ-003 SHALL have parameter CMD_TIMEOUT, default 5_000_000, meaning the maximum number of cycles allowed between a prefix byte and its argument byte.
REQ-004 SHALL have port clk50m, input, 1 bit: the single clock. All logic is in this domain.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port rx_valid, input, 1 bit: one-cycle strobe marking a received UART byte.
REQ-007 SHALL have port rx_data, input, 8 bits: the received byte, valid when rx_valid=1.
REQ-008 SHALL have port button, input, 1 bit: raw asynchronous push-button level; 1 = pressed.
REQ-009 SHALL have port frame_vsync, input, 1 bit: camera-domain ISP vsync, treated as asynchronous.
REQ-010 SHALL have port tx_valid, output, 1 bit: a response byte is available.
REQ-011 SHALL have port tx_data, output, 8 bits: the response byte.
REQ-012 SHALL have port tx_ready, input, 1 bit: the UART transmitter accepts the byte.
REQ-013 SHALL have port isp_mode, output, 4 bits: applied ISP display mode.
REQ-014 SHALL have port gamma_type, output, 2 bits: applied gamma select (1 = 1.8, 2 = 2.2, 3 = 2.4).
REQ-015 SHALL have port cmd_error, output, 1 bit: one-cycle pulse on any protocol error.

Function
REQ-016 SHALL pass button through a 2-FF synchronizer, then a debouncer: the stable level updates only after DEBOUNCE_CYCLES consecutive cycles of the same synchronized value.
REQ-017 SHALL generate one press event on each 0->1 transition of the stable level.
REQ-018 SHALL, on a press event, set pend_mode to pend_mode+1, or to 0 when pend_mode = MODE_NUM.
REQ-019 SHALL pass frame_vsync through a 2-FF synchronizer and detect the rising edge as apply_strobe.
REQ-020 SHALL, on apply_strobe, copy pend_mode to isp_mode and pend_gamma to gamma_type, using the pending values held before that cycle's updates.
REQ-021 SHALL never change isp_mode or gamma_type except on apply_strobe or reset.
REQ-022 SHALL run the command FSM with states IDLE, ARG_M, ARG_G, TX0, TX1.
REQ-023 In IDLE, on rx_valid: 'M' (8'h4D) -> ARG_M; 'G' (8'h47) -> ARG_G; '?' (8'h3F) -> TX0; any other byte -> cmd_error pulse, stay IDLE.
REQ-024 In ARG_M, byte '0'..('0'+MODE_NUM) SHALL set pend_mode to byte-8'h30 and go to IDLE; any other byte SHALL pulse cmd_error and go to IDLE.
REQ-025 In ARG_G, byte '1'..'3' SHALL set pend_gamma to byte-8'h30 and go to IDLE; any other byte SHALL pulse cmd_error and go to IDLE.
REQ-026 In ARG_M or ARG_G, a timeout counter reaching CMD_TIMEOUT without rx_valid SHALL pulse cmd_error and return to IDLE; the counter clears on entry to these states.
REQ-027 TX0 SHALL present tx_data = 8'h30+pend_mode and TX1 SHALL present tx_data = 8'h30+pend_gamma, each with tx_valid=1 and tx_data held stable until tx_ready=1.
REQ-028 TX0 advances to TX1, and TX1 to IDLE, on the cycle tx_valid&&tx_ready; a byte is transferred exactly once.
REQ-029 rx_valid during TX0/TX1 SHALL drop the byte and pulse cmd_error; the FSM is unaffected.
REQ-030 A UART pend_mode write and a press event in the same cycle: the UART value wins and the press is discarded.
REQ-031 A pend_mode/pend_gamma write in the same cycle as apply_strobe: the new pending value is applied at the next apply_strobe.
REQ-032 The '?' response SHALL report pending values, not applied values.

Reset
REQ-033 While reset_n=0: isp_mode=0, pend_mode=0, gamma_type=2, pend_gamma=2, tx_valid=0, tx_data=0, cmd_error=0, FSM=IDLE, all counters and synchronizers=0.
REQ-034 Reset asserted mid-command or mid-transmit SHALL abandon it; no residual byte is sent after release.

Structure
REQ-035 Command byte constants, FSM state encoding and gamma codes SHALL live in shared package isp_ctrl_pkg.
REQ-036 The synchronizer+debouncer+edge detector SHALL be sub-module btn_debounce; the vsync synchronizer reuses plain 2-FF logic inline.

Verification
REQ-037 Send 'M','3', then a vsync rising edge -> isp_mode 0->3 only 2-3 cycles after the edge, unchanged before it.
REQ-038 Send 'G','5' -> one cmd_error pulse, pend_gamma stays 2, FSM IDLE; then 'G','1' + vsync -> gamma_type=1.
REQ-039 DEBOUNCE_CYCLES=16: seven clean presses from mode 0 -> pending 1,2,...,6,0; a 10-cycle glitch -> no change.
REQ-040 Send '?' with tx_ready held 0 for 5 cycles -> tx_data=8'h30 held stable; then bytes 8'h30, 8'h32 are each accepted exactly once.
REQ-041 CMD_TIMEOUT=100: send 'M', then nothing for 100 cycles -> cmd_error pulse, IDLE; a following '4' -> cmd_error (unknown prefix).
REQ-042 Press event and 'M','5' argument in the same cycle, then assert reset_n=0 during a '?' response -> pending=5 before reset; after reset all outputs are at their reset values and tx_valid=0.
